// File: rtl/buttfly_pkg.sv
// Shared types and helpers for the butterfly datapath blocks.
package buttfly_pkg;

  // Default component width used across the butterfly datapath.
  localparam int W_DEFAULT = 8;

  // One complex sample at the default width.
  typedef struct packed {
    logic signed [W_DEFAULT-1:0] re;
    logic signed [W_DEFAULT-1:0] im;
  } cplx_t;

  // Rounding applied before the divide-by-two shift.
  typedef enum logic {
    RND_FLOOR   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  // Clamp a sign-extended (W+1)-bit value into the signed w-bit range.
  // The value arrives widened to 32 bits so one helper serves any W.
  function automatic logic signed [31:0] sat_to_w(input logic signed [31:0] v,
                                                  input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/buttfly_inv_pipe_if.sv
// Streaming valid/ready bundle for the inverse butterfly: input pair side
// and result pair side in one interface.
interface buttfly_inv_pipe_if
  import buttfly_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a_re;
  logic signed [W-1:0] a_im;
  logic signed [W-1:0] b_re;
  logic signed [W-1:0] b_im;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic signed [W-1:0] y0_re;
  logic signed [W-1:0] y0_im;
  logic signed [W-1:0] y1_re;
  logic signed [W-1:0] y1_im;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_valid, out_last, y0_re, y0_im, y1_re, y1_im
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_valid, out_last, y0_re, y0_im, y1_re, y1_im
  );
endinterface

// File: rtl/buttfly_rnd_sat.sv
// Round, halve and saturate one (W+1)-bit sum down to W bits.
module buttfly_rnd_sat
  import buttfly_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int ROUND = 1
) (
  input  logic signed [W:0]   i_sum,
  output logic signed [W-1:0] o_val,
  output logic                o_ovf
);
  // One extra bit of headroom: (2^W - 1) + 1 does not fit in W+1 bits.
  localparam logic [W+1:0] RND_ADD =
    (ROUND == int'(RND_HALF_UP)) ? (W+2)'(1) : (W+2)'(0);

  logic signed [W+1:0] w_rnd;
  logic signed [W:0]   w_shr;
  logic signed [31:0]  w_wide;
  logic signed [31:0]  w_sat;

  // Add the rounding bias, shift arithmetically, then clamp to W bits.
  always_comb begin
    w_rnd  = (W+2)'(i_sum) + RND_ADD;
    w_shr  = (W+1)'(w_rnd >>> 1);
    w_wide = 32'(w_shr);
    w_sat  = sat_to_w(w_wide, W);
    o_val  = w_sat[W-1:0];
    o_ovf  = (w_sat != w_wide);
  end
endmodule

// File: rtl/buttfly_inv_pipe.sv
// Two-stage inverse radix-2 butterfly: y0 = (a+b)/2, y1 = (a-b)/2 with
// rounding and saturation, valid/ready on both sides, frame tagging and a
// sticky saturation flag.
module buttfly_inv_pipe
  import buttfly_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int FRAME = 8,
  parameter int ROUND = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  buttfly_inv_pipe_if.slave  bus,
  input  logic               sat_clr,
  output logic               sat_flag
);
  localparam int CW = $clog2(FRAME);

  // Lane order in the arrays: 0 = y0_re, 1 = y0_im, 2 = y1_re, 3 = y1_im.
  logic signed [W:0]   w_sum [4];
  logic signed [W-1:0] w_y   [4];
  logic [3:0]          w_ovf;
  logic                w_s1_adv;
  logic                w_in_ready;
  logic                w_in_xfer;
  logic                w_last;

  logic                r_s1_valid;
  logic signed [W:0]   r_s1_sum [4];
  logic                r_s1_last;
  logic                r_s2_valid;
  logic signed [W-1:0] r_y [4];
  logic                r_s2_last;
  logic                r_sat;
  logic [CW-1:0]       r_cnt;

  // Handshake and frame-position decode; stage 2 frees up when empty or draining.
  always_comb begin
    w_s1_adv   = !r_s2_valid || bus.out_ready;
    w_in_ready = !r_s1_valid || w_s1_adv;
    w_in_xfer  = bus.in_valid && w_in_ready;
    w_last     = (r_cnt == CW'(FRAME - 1));
  end

  // Sign-extended sums and differences for the four output lanes.
  always_comb begin
    w_sum[0] = (W+1)'(bus.a_re) + (W+1)'(bus.b_re);
    w_sum[1] = (W+1)'(bus.a_im) + (W+1)'(bus.b_im);
    w_sum[2] = (W+1)'(bus.a_re) - (W+1)'(bus.b_re);
    w_sum[3] = (W+1)'(bus.a_im) - (W+1)'(bus.b_im);
  end

  for (genvar g = 0; g < 4; g++) begin : g_rs
    buttfly_rnd_sat #(.W(W), .ROUND(ROUND)) u_rnd_sat (
      .i_sum (r_s1_sum[g]),
      .o_val (w_y[g]),
      .o_ovf (w_ovf[g])
    );
  end

  // Stage 1: capture sums on an input transfer; valid follows whenever it may load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '{default: '0};
      r_s1_last  <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_xfer) begin
        r_s1_sum  <= w_sum;
        r_s1_last <= w_last;
      end
    end
  end

  // Stage 2: register rounded results; data only moves when stage 1 hands over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_y        <= '{default: '0};
      r_s2_last  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_adv && r_s1_valid) begin
        r_y       <= w_y;
        r_s2_last <= r_s1_last;
      end
    end
  end

  // Sticky saturation flag; a new saturation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_s1_adv && r_s1_valid && (|w_ovf)) begin
      r_sat <= 1'b1;
    end else if (sat_clr) begin
      r_sat <= 1'b0;
    end
  end

  // Frame position counter, advancing only on accepted pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_in_xfer) begin
      r_cnt <= w_last ? CW'(0) : r_cnt + CW'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_last  = r_s2_last;
  assign bus.y0_re     = r_y[0];
  assign bus.y0_im     = r_y[1];
  assign bus.y1_re     = r_y[2];
  assign bus.y1_im     = r_y[3];
  assign sat_flag      = r_sat;
endmodule

// File: tb/tb_buttfly_inv_pipe.sv
// Directed bench for buttfly_inv_pipe: one instance with round-half-up and
// one with floor, fed identical stimulus.
module tb_buttfly_inv_pipe;
  import buttfly_pkg::*;

  localparam int W     = 8;
  localparam int FRAME = 8;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic sat_clr = 1'b0;
  logic sat1;
  logic sat0;
  int   n_total = 0;
  int   n_bad   = 0;

  buttfly_inv_pipe_if #(.W(W)) bus1 ();
  buttfly_inv_pipe_if #(.W(W)) bus0 ();

  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.a_re      = bus1.a_re;
  assign bus0.a_im      = bus1.a_im;
  assign bus0.b_re      = bus1.b_re;
  assign bus0.b_im      = bus1.b_im;
  assign bus0.out_ready = bus1.out_ready;

  buttfly_inv_pipe #(.W(W), .FRAME(FRAME), .ROUND(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .sat_clr(sat_clr), .sat_flag(sat1)
  );

  buttfly_inv_pipe #(.W(W), .FRAME(FRAME), .ROUND(0)) u_dut_floor (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .sat_clr(sat_clr), .sat_flag(sat0)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi);
    bus1.a_re = W'(ar);
    bus1.a_im = W'(ai);
    bus1.b_re = W'(br);
    bus1.b_im = W'(bi);
  endtask

  function automatic logic [31:0] pack_out();
    return {bus1.y0_re, bus1.y0_im, bus1.y1_re, bus1.y1_im};
  endfunction

  // Stream pair k is a=(4k,-2k), b=(2k,0): y0=(3k,-k), y1=(k,-k), all exact.
  function automatic logic [31:0] exp_pack(input int k);
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] r;
    p = 8'(3 * k);
    q = 8'(-k);
    r = 8'(k);
    return {p, q, r, q};
  endfunction

  // One pair into an empty pipe; returns at the negedge where it is on the output.
  task automatic send_pair(input int ar, input int ai, input int br, input int bi,
                           input bit clr);
    @(negedge clk);
    drive(ar, ai, br, bi);
    bus1.in_valid  = 1'b1;
    bus1.out_ready = 1'b1;
    sat_clr        = clr;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check_val("lat_edge1_valid", bus1.out_valid, 0);
    if (clr) check_val("clr_before_set", sat1, 0);
    @(negedge clk);
    sat_clr = 1'b0;
    check_val("lat_edge2_valid", bus1.out_valid, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus1.in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_stream(input int n, input bit stall, input string tag);
    int         sent = 0;
    int         got  = 0;
    int         cyc  = 0;
    bit         held = 1'b0;
    logic [31:0] held_data = 32'h0;
    logic        held_last = 1'b0;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      bus1.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus1.in_valid  = (sent < n);
      drive(4 * sent, -2 * sent, 2 * sent, 0);
      #1;
      if (held) begin
        check_val({tag, "_hold_valid"}, bus1.out_valid, 1);
        check_val({tag, "_hold_data"}, pack_out(), held_data);
        check_val({tag, "_hold_last"}, bus1.out_last, held_last);
      end
      check_val({tag, "_in_ready"}, bus1.in_ready,
                ((sent - got) == 2 && !bus1.out_ready) ? 0 : 1);
      if (bus1.out_valid && bus1.out_ready) begin
        check_val({tag, "_data"}, pack_out(), exp_pack(got));
        check_val({tag, "_last"}, bus1.out_last, ((got + 1) % FRAME) == 0);
        got++;
      end
      held      = bus1.out_valid && !bus1.out_ready;
      held_data = pack_out();
      held_last = bus1.out_last;
      if (bus1.in_valid && bus1.in_ready) sent++;
      cyc++;
    end
    check_val({tag, "_count"}, got, n);
    bus1.in_valid = 1'b0;
  endtask

  initial begin
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    drive(0, 0, 0, 0);

    // Reset state.
    #1;
    check_val("rst_out_valid", bus1.out_valid, 0);
    check_val("rst_sat1", sat1, 0);
    check_val("rst_sat0", sat0, 0);
    check_val("rst_y0_re", bus1.y0_re, 0);
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", bus1.in_ready, 1);

    // Basic pair: (14+1)>>1=7, (-4+1)>>1=-2, (6+1)>>1=3, (-8+1)>>1=-4.
    send_pair(10, -6, 4, 2, 1'b0);
    check_val("basic_y0_re", bus1.y0_re, 7);
    check_val("basic_y0_im", bus1.y0_im, -2);
    check_val("basic_y1_re", bus1.y1_re, 3);
    check_val("basic_y1_im", bus1.y1_im, -4);
    check_val("basic_sat", sat1, 0);

    // Rounding mode: 3/2 -> 2 vs 1, -3/2 -> -1 vs -2.
    send_pair(3, 0, 0, 0, 1'b0);
    check_val("rnd_pos_half_up", bus1.y0_re, 2);
    check_val("rnd_pos_floor", bus0.y0_re, 1);
    send_pair(-3, 0, 0, 0, 1'b0);
    check_val("rnd_neg_half_up", bus1.y0_re, -1);
    check_val("rnd_neg_floor", bus0.y0_re, -2);

    // Saturation: re diff 255 -> (256>>1)=128 clamps to 127 with half-up;
    // im diff -255 -> -127 with half-up, -128 with floor; sums -1 -> 0 / -1.
    send_pair(127, -128, -128, 127, 1'b0);
    check_val("sat_y1_re", bus1.y1_re, 127);
    check_val("sat_y1_im", bus1.y1_im, -127);
    check_val("sat_y0_re", bus1.y0_re, 0);
    check_val("sat_y0_im", bus1.y0_im, 0);
    check_val("sat_flag_set", sat1, 1);
    check_val("sat_floor_y1_re", bus0.y1_re, 127);
    check_val("sat_floor_y1_im", bus0.y1_im, -128);
    check_val("sat_floor_y0_re", bus0.y0_re, -1);
    check_val("sat_floor_flag", sat0, 0);

    // Clear held across a new saturation: clear takes effect first, then set wins.
    send_pair(127, -128, -128, 127, 1'b1);
    check_val("sat_set_wins", sat1, 1);
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check_val("sat_clr", sat1, 0);

    // Backpressure stream with random stalls (frames split by stalls).
    pulse_reset();
    run_stream(20, 1'b1, "bp");

    // Back-to-back frame run: last on outputs 8 and 16 only.
    pulse_reset();
    run_stream(17, 1'b0, "frame");

    // Async reset with two pairs in flight and downstream stalled.
    @(negedge clk);
    bus1.out_ready = 1'b0;
    drive(1, 1, 1, 1);
    bus1.in_valid  = 1'b1;
    @(negedge clk);
    drive(2, 2, 2, 2);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check_val("inflight_valid", bus1.out_valid, 1);
    check_val("inflight_in_ready", bus1.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", bus1.out_valid, 0);
    check_val("async_rst_in_ready", bus1.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_no_pulse", bus1.out_valid, 0);
    run_stream(8, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
